// File: rtl/asin_lookup.sv
// Arcsine lookup: successive-approximation search of a quarter-wave sine ROM,
// nearest-degree rounding, then quadrant mapping to an angle in 0..359.
module asin_lookup #(
  parameter int SCALE_BITS = 12
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [12:0] magnitude,
  input  logic        negative,
  input  logic        cos_negative,
  output logic [8:0]  angle,
  output logic        busy,
  output logic        done
);

  localparam logic [12:0] FULL = 13'(1 << SCALE_BITS);

  typedef enum logic [2:0] {IDLE, SEARCH, REFINE, MAP, DONE} state_t;

  state_t      state, state_nx;
  logic        ph;
  logic [2:0]  bit_idx;
  logic [6:0]  d, trial, rom_addr;
  logic [12:0] value, lo, rom_q;
  logic        neg_q, cneg_q;
  logic [8:0]  map_q;

  // entry d = round(4096 * sin(d deg))
  function automatic logic [12:0] rom_val(input logic [6:0] a);
    logic [12:0] v;
    v = 13'd0;
    case (a)
      7'd0:  v = 13'd0;    7'd1:  v = 13'd71;   7'd2:  v = 13'd143;  7'd3:  v = 13'd214;
      7'd4:  v = 13'd286;  7'd5:  v = 13'd357;  7'd6:  v = 13'd428;  7'd7:  v = 13'd499;
      7'd8:  v = 13'd570;  7'd9:  v = 13'd641;  7'd10: v = 13'd711;  7'd11: v = 13'd782;
      7'd12: v = 13'd852;  7'd13: v = 13'd921;  7'd14: v = 13'd991;  7'd15: v = 13'd1060;
      7'd16: v = 13'd1129; 7'd17: v = 13'd1198; 7'd18: v = 13'd1266; 7'd19: v = 13'd1334;
      7'd20: v = 13'd1401; 7'd21: v = 13'd1468; 7'd22: v = 13'd1534; 7'd23: v = 13'd1600;
      7'd24: v = 13'd1666; 7'd25: v = 13'd1731; 7'd26: v = 13'd1796; 7'd27: v = 13'd1860;
      7'd28: v = 13'd1923; 7'd29: v = 13'd1986; 7'd30: v = 13'd2048; 7'd31: v = 13'd2110;
      7'd32: v = 13'd2171; 7'd33: v = 13'd2231; 7'd34: v = 13'd2290; 7'd35: v = 13'd2349;
      7'd36: v = 13'd2408; 7'd37: v = 13'd2465; 7'd38: v = 13'd2522; 7'd39: v = 13'd2578;
      7'd40: v = 13'd2633; 7'd41: v = 13'd2687; 7'd42: v = 13'd2741; 7'd43: v = 13'd2793;
      7'd44: v = 13'd2845; 7'd45: v = 13'd2896; 7'd46: v = 13'd2946; 7'd47: v = 13'd2996;
      7'd48: v = 13'd3044; 7'd49: v = 13'd3091; 7'd50: v = 13'd3138; 7'd51: v = 13'd3183;
      7'd52: v = 13'd3228; 7'd53: v = 13'd3271; 7'd54: v = 13'd3314; 7'd55: v = 13'd3355;
      7'd56: v = 13'd3396; 7'd57: v = 13'd3435; 7'd58: v = 13'd3474; 7'd59: v = 13'd3511;
      7'd60: v = 13'd3547; 7'd61: v = 13'd3582; 7'd62: v = 13'd3617; 7'd63: v = 13'd3650;
      7'd64: v = 13'd3681; 7'd65: v = 13'd3712; 7'd66: v = 13'd3742; 7'd67: v = 13'd3770;
      7'd68: v = 13'd3798; 7'd69: v = 13'd3824; 7'd70: v = 13'd3849; 7'd71: v = 13'd3873;
      7'd72: v = 13'd3896; 7'd73: v = 13'd3917; 7'd74: v = 13'd3937; 7'd75: v = 13'd3956;
      7'd76: v = 13'd3974; 7'd77: v = 13'd3991; 7'd78: v = 13'd4006; 7'd79: v = 13'd4021;
      7'd80: v = 13'd4034; 7'd81: v = 13'd4046; 7'd82: v = 13'd4056; 7'd83: v = 13'd4065;
      7'd84: v = 13'd4074; 7'd85: v = 13'd4080; 7'd86: v = 13'd4086; 7'd87: v = 13'd4090;
      7'd88: v = 13'd4094; 7'd89: v = 13'd4095; 7'd90: v = 13'd4096;
      default: v = 13'd0;
    endcase
    return v;
  endfunction

  assign trial = d | (7'd1 << bit_idx);
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rom_addr = d;
    case (state)
      IDLE:   if (start) state_nx = SEARCH;
      SEARCH: begin
        rom_addr = trial;
        if (ph && bit_idx == 3'd0) state_nx = REFINE;
      end
      REFINE: begin
        if (d < 7'd90) rom_addr = d + 7'd1;
        if (ph) state_nx = MAP;
      end
      MAP:    if (ph) state_nx = DONE;
      DONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ph alternates issue/compare within a state and restarts on every state change
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph      <= 1'b0;
      bit_idx <= 3'd0;
      d       <= 7'd0;
      lo      <= 13'd0;
      value   <= 13'd0;
      neg_q   <= 1'b0;
      cneg_q  <= 1'b0;
      rom_q   <= 13'd0;
      map_q   <= 9'd0;
      angle   <= 9'd0;
    end else begin
      ph    <= (state_nx == state) ? ~ph : 1'b0;
      rom_q <= rom_val(rom_addr);
      case (state)
        IDLE: if (start) begin
          value   <= (magnitude > FULL) ? FULL : magnitude;
          neg_q   <= negative;
          cneg_q  <= cos_negative;
          d       <= 7'd0;
          lo      <= 13'd0;
          bit_idx <= 3'd6;
        end
        SEARCH: if (ph) begin
          if (trial <= 7'd90 && rom_q <= value) begin
            d  <= trial;
            lo <= rom_q;
          end
          if (bit_idx != 3'd0) bit_idx <= bit_idx - 3'd1;
        end
        // rom_q holds rom[d+1] here; lo holds rom[d], so neither difference can underflow
        REFINE: if (ph && d < 7'd90 && (rom_q - value) < (value - lo)) d <= d + 7'd1;
        MAP: begin
          if (!ph) begin
            case ({neg_q, cneg_q})
              2'b00:   map_q <= {2'b00, d};
              2'b01:   map_q <= 9'd180 - {2'b00, d};
              2'b11:   map_q <= 9'd180 + {2'b00, d};
              default: map_q <= (d == 7'd0) ? 9'd0 : 9'd360 - {2'b00, d};
            endcase
          end else begin
            angle <= map_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
